// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store access controller.
//   - DATA_W / ADDR_W : data and address widths of the MCU data memory
//   - lsu_op_e        : request operation encodings
//   - lsu_state_e     : controller sequencing states
package lsu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    LSU_LOAD  = 2'b00,
    LSU_STORE = 2'b01,
    LSU_INC   = 2'b10,
    LSU_SWAP  = 2'b11
  } lsu_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_access_ctrl.sv
// lsu_access_ctrl: one-at-a-time load/store controller in front of the MCU
// data memory. Sequences the memory's single wr_rd port through read,
// capture and write phases and returns a single-cycle response.
//
// Ports:
//   lsu_clk, lsu_rst      : clock (shared with memory), sync active-high reset
//   lsu_req_*             : valid/ready request (op, base, offset, wdata)
//   lsu_rsp_valid/rdata   : one-cycle response pulse, data held afterwards
//   lsu_busy              : !lsu_req_ready
//   lsu_mem_address/data_in/wr_rd : drive the data memory (1 = write)
//   lsu_mem_data_out      : registered memory read data
//
// Operation flows:
//   LOAD       : IDLE -> RD -> CAP -> RSP
//   STORE      : IDLE -> WR -> RSP
//   INC / SWAP : IDLE -> RD -> CAP -> WR -> RSP
module lsu_access_ctrl
  import lsu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          lsu_clk,
  input  logic          lsu_rst,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic [1:0]    lsu_req_op,
  input  logic [AW-1:0] lsu_req_base,
  input  logic [AW-1:0] lsu_req_offset,
  input  logic [DW-1:0] lsu_req_wdata,
  output logic          lsu_rsp_valid,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          lsu_busy,
  output logic [AW-1:0] lsu_mem_address,
  output logic [DW-1:0] lsu_mem_data_in,
  output logic          lsu_mem_wr_rd,
  input  logic [DW-1:0] lsu_mem_data_out
);

  lsu_state_e    state;
  lsu_op_e       op_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] old_q;

  assign lsu_req_ready = (state == IDLE);
  assign lsu_busy      = ~lsu_req_ready;

  // All memory-facing and response outputs are registered: each transition
  // loads the values the next state presents for its whole cycle.
  always_ff @(posedge lsu_clk) begin
    if (lsu_rst) begin
      state           <= IDLE;
      op_q            <= LSU_LOAD;
      wdata_q         <= '0;
      old_q           <= '0;
      lsu_rsp_valid   <= 1'b0;
      lsu_rsp_rdata   <= '0;
      lsu_mem_address <= '0;
      lsu_mem_data_in <= '0;
      lsu_mem_wr_rd   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_req_valid) begin
            op_q            <= lsu_op_e'(lsu_req_op);
            wdata_q         <= lsu_req_wdata;
            // effective address wraps within the 256-byte space
            lsu_mem_address <= lsu_req_base + lsu_req_offset;
            if (lsu_op_e'(lsu_req_op) == LSU_STORE) begin
              // store needs no read: go straight to the write cycle
              lsu_mem_data_in <= lsu_req_wdata;
              lsu_mem_wr_rd   <= 1'b1;
              state           <= WR;
            end else begin
              lsu_mem_wr_rd <= 1'b0;
              state         <= RD;
            end
          end
        end
        RD: begin
          // memory samples the address at the end of RD; data appears in CAP
          state <= CAP;
        end
        CAP: begin
          old_q <= lsu_mem_data_out;
          if (op_q == LSU_LOAD) begin
            lsu_rsp_valid <= 1'b1;
            lsu_rsp_rdata <= lsu_mem_data_out;
            state         <= RSP;
          end else begin
            lsu_mem_data_in <= (op_q == LSU_INC) ? lsu_mem_data_out + DW'(1)
                                                 : wdata_q;
            lsu_mem_wr_rd   <= 1'b1;
            state           <= WR;
          end
        end
        WR: begin
          lsu_mem_wr_rd <= 1'b0;
          lsu_rsp_valid <= 1'b1;
          lsu_rsp_rdata <= (op_q == LSU_STORE) ? wdata_q : old_q;
          state         <= RSP;
        end
        RSP: begin
          lsu_rsp_valid <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          lsu_rsp_valid <= 1'b0;
          lsu_mem_wr_rd <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_access_ctrl.md
# lsu_access_ctrl

Load/store access controller that sits directly upstream of the MCU data memory (`data_memoryfile`). It accepts one memory request at a time from the core over a valid/ready handshake and computes an 8-bit effective address. It sequences the memory's single `wr_rd` port through read, capture and write phases, and returns a one-cycle response. Supported operations are load, store, increment-in-memory (read-modify-write) and swap.

## Interface
- `DATA_W`, 8: data width; must match the data memory.
- `ADDR_W`, 8: address width; the address space is 256 bytes.
- `lsu_clk`  in  1: single clock, shared with the data memory.
- `lsu_rst`  in  1: synchronous, active-high reset.
- `lsu_req_valid`  in  1: core presents a request.
- `lsu_req_ready`  out  1: controller can accept; equals (state == IDLE).
- `lsu_req_op`  in  2: operation; 00 LOAD, 01 STORE, 10 INC, 11 SWAP.
- `lsu_req_base`  in  8: base address.
- `lsu_req_offset`  in  8: unsigned offset.
- `lsu_req_wdata`  in  8: store or swap data.
- `lsu_rsp_valid`  out  1: one-cycle response pulse; no backpressure.
- `lsu_rsp_rdata`  out  8: response data.
- `lsu_busy`  out  1: equals !lsu_req_ready.
- `lsu_mem_address`  out  8: to `data_mem_address`.
- `lsu_mem_data_in`  out  8: to `data_mem_data_in`.
- `lsu_mem_wr_rd`  out  1: to `data_mem_wr_rd`; 1 = write, 0 = read.
- `lsu_mem_data_out`  in  8: from `data_mem_data_out`; registered, valid the cycle after a read cycle.

## Operation
- Accept occurs on a clock edge where valid && ready. At that edge the controller latches op, wdata, and ea = (base + offset) mod 256, with the carry discarded.
- States are IDLE, RD, CAP, WR, RSP.
  - LOAD: IDLE → RD → CAP → RSP → IDLE.
  - STORE: IDLE → WR → RSP → IDLE.
  - INC and SWAP: IDLE → RD → CAP → WR → RSP → IDLE.
- RD: drive mem_address = ea and wr_rd = 0; the memory samples at the end of this cycle.
- CAP: at the end of this cycle, latch old = lsu_mem_data_out.
- WR: drive wr_rd = 1 and mem_address = ea.
  - mem_data_in = wdata for STORE and SWAP.
  - mem_data_in = (old + 1) mod 256 for INC.
- RSP: lsu_rsp_valid = 1 for exactly one cycle.
  - rsp_rdata = old for LOAD, INC and SWAP.
  - rsp_rdata = wdata for STORE.
- lsu_mem_wr_rd is 1 only in WR, so there is exactly one write cycle per STORE, INC or SWAP. It is 0 in every other state, including IDLE.
- lsu_mem_address holds ea from RD or WR through RSP, and keeps its last value in IDLE.
- rsp_rdata holds its value after RSP until the next response.
- Requests presented while busy are ignored; the core must hold them until ready.

## Timing
- Accept edge = cycle 0.
- LOAD: rsp_valid in cycle 3; ready again in cycle 4.
- STORE: write in cycle 1; rsp_valid in cycle 2; ready in cycle 3.
- INC and SWAP: write in cycle 3; rsp_valid in cycle 4; ready in cycle 5.
- Reset values:
  - state IDLE, so ready = 1 and busy = 0 from the first post-reset cycle.
  - rsp_valid = 0, rsp_rdata = 0x00.
  - mem_address = 0x00, mem_data_in = 0x00, mem_wr_rd = 0.
- Reset mid-operation: the next edge returns to IDLE with no response.
  - A reset asserted in RD or CAP prevents any write.
  - A reset asserted during WR does not cancel that write. The memory is not reset and samples wr_rd = 1 on the same edge.
- Simultaneous valid with reset: reset wins and nothing is accepted.
- Address wrap: for example, base 0xF0 + offset 0x20 gives ea 0x10.
- INC wrap: 0xFF becomes 0x00.

## Structure
- Shared package `lsu_pkg` holds:
  - the op encodings (LSU_LOAD, LSU_STORE, LSU_INC, LSU_SWAP);
  - the state enum;
  - DATA_W and ADDR_W.
- The block is a single module with no sub-modules. The effective-address adder and the increment are inline.
- The testbench instantiates `lsu_access_ctrl` together with `data_memoryfile` on a common clock. Memory powers up with mem[i] = i.

## Test plan
- Reset, then LOAD base 0x10 offset 0x05 → rsp_valid in cycle 3 with rdata 0x15; wr_rd stays 0 throughout; ready returns in cycle 4.
- STORE base 0xF0 offset 0x20 wdata 0xAB → mem_address 0x10 with wr_rd = 1 for exactly cycle 1; rsp rdata 0xAB; a following LOAD of 0x10 returns 0xAB.
- INC at 0xFF → rsp rdata 0xFF in cycle 4; a following LOAD of 0xFF returns 0x00.
- SWAP at 0x40 wdata 0x99 → rsp rdata 0x40; a following LOAD of 0x40 returns 0x99.
- Hold req_valid high with LOAD, STORE, INC back-to-back:
  - exactly one response per accept;
  - no accept while busy;
  - the response sequence is 0x21, wdata, 0x31 for addresses 0x21, 0x22, 0x31.
- Assert reset in the CAP cycle of INC at 0x20 → no rsp_valid and wr_rd never 1; ready = 1 after reset; LOAD of 0x20 returns 0x20.
